// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC register, same-cycle memory read, prefetch queue
// toward decode with valid/ready, redirect flush.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        Ready,
    output logic        Valid,
    output logic [31:0] InstOut,
    output logic [31:0] PCOut,
    output logic [31:0] PC4Out,
    output logic        Misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   ent_pc_q   [DEPTH];
    logic [31:0]   ent_pc_d   [DEPTH];
    logic [31:0]   ent_inst_q [DEPTH];
    logic [31:0]   ent_inst_d [DEPTH];

    logic deq;
    logic enq;

    assign Valid    = (count_q != '0);
    assign deq      = Valid & Ready;
    assign enq      = !Redirect & ((count_q < CW'(DEPTH)) | deq);
    assign Addr     = pc_q;
    assign InstOut  = ent_inst_q[rd_ptr_q];
    assign PCOut    = ent_pc_q[rd_ptr_q];
    assign PC4Out   = PCOut + 32'd4;
    assign Misalign = misalign_q;

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        ent_pc_d   = ent_pc_q;
        ent_inst_d = ent_inst_q;
        if (Redirect) begin
            // Flush drops queued entries and the word currently on Inst.
            pc_d       = {Target[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            misalign_d = |Target[1:0];
        end else begin
            if (enq) begin
                ent_pc_d[wr_ptr_q]   = pc_q;
                ent_inst_d[wr_ptr_q] = Inst;
                pc_d                 = pc_q + 32'd4;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]   <= '0;
                ent_inst_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            ent_pc_q   <= ent_pc_d;
            ent_inst_q <= ent_inst_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Redirect;
    logic [31:0] Target;
    logic        Ready;
    logic        Valid;
    logic [31:0] InstOut;
    logic [31:0] PCOut;
    logic [31:0] PC4Out;
    logic        Misalign;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Clrn(Clrn), .Addr(Addr), .Inst(Inst),
        .Redirect(Redirect), .Target(Target), .Ready(Ready),
        .Valid(Valid), .InstOut(InstOut), .PCOut(PCOut),
        .PC4Out(PC4Out), .Misalign(Misalign)
    );

    always #5 Clk = ~Clk;

    assign Inst = mem[Addr[6:2]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {pc, inst} fed from the model's own PC.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc  = RESET_PC;
    logic        m_mis = 1'b0;

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            mq.delete();
            m_pc  = RESET_PC;
            m_mis = 1'b0;
        end else if (Redirect) begin
            mq.delete();
            m_pc  = {Target[31:2], 2'b00};
            m_mis = (Target[1:0] != 2'b00);
        end else begin
            if (mq.size() > 0 && Ready) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back('{pc: m_pc, inst: mem[m_pc[6:2]]});
                m_pc = m_pc + 32'd4;
            end
            m_mis = 1'b0;
        end
    end

    always @(posedge Clk) begin
        #1;
        if (Clrn === 1'b1) begin
            chk("m_valid", {31'd0, Valid}, {31'd0, mq.size() > 0});
            chk("m_addr", Addr, m_pc);
            chk("m_misalign", {31'd0, Misalign}, {31'd0, m_mis});
            if (mq.size() > 0) begin
                chk("m_pcout", PCOut, mq[0].pc);
                chk("m_instout", InstOut, mq[0].inst);
                chk("m_pc4out", PC4Out, mq[0].pc + 32'd4);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        mem[0]  = 32'h3401_000A;
        mem[1]  = 32'h2002_0006;
        mem[12] = 32'h1022_0004;
        Clrn     = 1'b0;
        Redirect = 1'b0;
        Target   = '0;
        Ready    = 1'b1;
        #12;
        chk("rst_valid", {31'd0, Valid}, 32'd0);
        chk("rst_addr", Addr, RESET_PC);
        chk("rst_instout", InstOut, 32'd0);
        chk("rst_pcout", PCOut, 32'd0);
        chk("rst_pc4out", PC4Out, 32'd4);
        chk("rst_misalign", {31'd0, Misalign}, 32'd0);
        #2 Clrn = 1'b1;

        // Streaming with Ready held high
        step();
        chk("t1_valid", {31'd0, Valid}, 32'd1);
        chk("t1_pc0", PCOut, 32'h0);
        chk("t1_inst0", InstOut, 32'h3401_000A);
        chk("t1_addr4", Addr, 32'h4);
        step();
        chk("t1_pc1", PCOut, 32'h4);
        chk("t1_inst1", InstOut, 32'h2002_0006);
        chk("t1_addr8", Addr, 32'h8);

        // Asynchronous reset between edges, then backpressure from reset
        Clrn  = 1'b0;
        Ready = 1'b0;
        #1;
        chk("t6_valid", {31'd0, Valid}, 32'd0);
        chk("t6_addr", Addr, RESET_PC);
        #2 Clrn = 1'b1;
        step();
        chk("t2_addr4", Addr, 32'h4);
        step();
        chk("t2_addr8", Addr, 32'h8);
        step();
        chk("t2_hold_addr", Addr, 32'h8);
        chk("t2_hold_pc", PCOut, 32'h0);
        chk("t2_hold_inst", InstOut, 32'h3401_000A);
        Ready = 1'b1;
        step();
        chk("t2_seq4", PCOut, 32'h4);
        step();
        chk("t2_seq8", PCOut, 32'h8);
        step();
        chk("t2_seqc", PCOut, 32'hC);

        // Redirect while full
        Ready = 1'b0;
        step();
        Redirect = 1'b1;
        Target   = 32'h30;
        step();
        chk("t3_valid0", {31'd0, Valid}, 32'd0);
        chk("t3_addr", Addr, 32'h30);
        Redirect = 1'b0;
        step();
        chk("t3_valid1", {31'd0, Valid}, 32'd1);
        chk("t3_pc", PCOut, 32'h30);
        chk("t3_inst", InstOut, 32'h1022_0004);

        // Misaligned target
        Redirect = 1'b1;
        Target   = 32'h31;
        step();
        chk("t4_addr", Addr, 32'h30);
        chk("t4_mis1", {31'd0, Misalign}, 32'd1);
        Redirect = 1'b0;
        step();
        chk("t4_mis0", {31'd0, Misalign}, 32'd0);
        chk("t4_pc", PCOut, 32'h30);

        // Redirect and Ready together: flush wins
        Ready    = 1'b1;
        Redirect = 1'b1;
        Target   = 32'h40;
        step();
        chk("t5_valid0", {31'd0, Valid}, 32'd0);
        Redirect = 1'b0;
        step();
        chk("t5_pc", PCOut, 32'h40);
        chk("t5_inst", InstOut, 32'hA000_0010);
        step();
        chk("t5_pc_next", PCOut, 32'h44);

        // PC wraps past the top of the address space
        Redirect = 1'b1;
        Target   = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        step();
        chk("wrap_pc", PCOut, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC4Out, 32'h0);
        chk("wrap_addr", Addr, 32'h0);
        step();
        chk("wrap_next", PCOut, 32'h0);

        // Restart after reset, mid-stream
        step();
        Clrn = 1'b0;
        #1;
        chk("t6b_valid", {31'd0, Valid}, 32'd0);
        chk("t6b_addr", Addr, RESET_PC);
        #2 Clrn = 1'b1;
        step();
        chk("t6b_pc", PCOut, RESET_PC);
        chk("t6b_inst", InstOut, 32'h3401_000A);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
